// File: rtl/pool_pkg.sv
// Shared definitions for the streaming pooling engine: mode encoding,
// compile-time log2 and accumulator width derivation.
package pool_pkg;

  localparam logic MODE_AVG = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // A full POOL x POOL window sum needs 2*log2(POOL) extra bits of headroom.
  function automatic int acc_width(input int res, input int pool);
    return res + 2 * clog2(pool);
  endfunction

endpackage

// File: rtl/pool_combine.sv
// Combinational window update: folds one pixel into a column accumulator and
// produces the rounded-average or max result when the window completes.
module pool_combine
  import pool_pkg::*;
#(
  parameter int RESOLUTION = 8,
  parameter int POOL       = 2,
  localparam int ACC_W     = acc_width(RESOLUTION, POOL)
) (
  input  logic                  mode,
  input  logic [ACC_W-1:0]      acc,
  input  logic [RESOLUTION-1:0] pixel,
  input  logic                  is_origin,
  input  logic                  is_final,
  output logic [ACC_W-1:0]      acc_next,
  output logic [RESOLUTION-1:0] pix_out
);

  localparam int            SH   = 2 * clog2(POOL);
  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'((POOL * POOL) / 2);

  logic [ACC_W-1:0] pix_ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] mx;
  logic [ACC_W:0]   rnd;

  function automatic logic [RESOLUTION-1:0] sat_pix(input logic [ACC_W:0] v);
    return (|v[ACC_W:RESOLUTION]) ? '1 : v[RESOLUTION-1:0];
  endfunction

  assign pix_ext = ACC_W'(pixel);
  assign sum     = acc + pix_ext;
  assign mx      = (pix_ext > acc) ? pix_ext : acc;
  // Round half up: add half the divisor before the shift.
  assign rnd     = ({1'b0, sum} + HALF) >> SH;

  always_comb begin
    acc_next = is_origin ? pix_ext : ((mode == MODE_MAX) ? mx : sum);
    pix_out  = '0;
    if (is_final)
      pix_out = (mode == MODE_MAX) ? sat_pix({1'b0, mx}) : sat_pix(rnd);
  end

endmodule

// File: rtl/stream_pool2d.sv
// Streaming 2-D pooling engine: raster-order pixels in, one pooled pixel per
// POOL x POOL window out, with valid/ready on both sides and frame alignment check.
module stream_pool2d
  import pool_pkg::*;
#(
  parameter int RESOLUTION = 8,
  parameter int IMG_WIDTH  = 4,
  parameter int IMG_HEIGHT = 4,
  parameter int POOL       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RESOLUTION-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RESOLUTION-1:0] out_data,
  output logic                  out_last,
  output logic                  frame_err
);

  localparam int ACC_W = acc_width(RESOLUTION, POOL);
  localparam int LP    = clog2(POOL);
  localparam int NWIN  = IMG_WIDTH / POOL;
  localparam int CW    = (clog2(IMG_WIDTH) > 0) ? clog2(IMG_WIDTH) : 1;
  localparam int RW    = (clog2(IMG_HEIGHT) > 0) ? clog2(IMG_HEIGHT) : 1;
  localparam int AW    = (clog2(NWIN) > 0) ? clog2(NWIN) : 1;

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [ACC_W-1:0]      acc [NWIN];
  logic                  mode_q;
  logic                  accept;
  logic                  at_first;
  logic                  at_last_pos;
  logic                  is_origin;
  logic                  is_final;
  logic                  eff_mode;
  logic                  early_last;
  logic [AW-1:0]         a_idx;
  logic [ACC_W-1:0]      acc_nxt;
  logic [RESOLUTION-1:0] pix_res;

  assign in_ready    = (~out_valid | out_ready) & ~clear;
  assign accept      = in_valid & in_ready;
  assign at_first    = (col == '0) && (row == '0);
  assign at_last_pos = (col == CW'(IMG_WIDTH - 1)) && (row == RW'(IMG_HEIGHT - 1));
  assign is_origin   = (col[LP-1:0] == '0) && (row[LP-1:0] == '0);
  assign is_final    = (&col[LP-1:0]) && (&row[LP-1:0]);
  assign a_idx       = AW'(col >> LP);
  // The first pixel of a frame must already see the new mode.
  assign eff_mode    = at_first ? mode : mode_q;
  assign early_last  = in_last & ~at_last_pos;

  pool_combine #(
    .RESOLUTION(RESOLUTION),
    .POOL      (POOL)
  ) u_combine (
    .mode     (eff_mode),
    .acc      (acc[a_idx]),
    .pixel    (in_data),
    .is_origin(is_origin),
    .is_final (is_final),
    .acc_next (acc_nxt),
    .pix_out  (pix_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (early_last) begin
        col <= '0;
        row <= '0;
      end else if (col == CW'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NWIN; i++) acc[i] <= '0;
      mode_q <= MODE_AVG;
    end else if (accept) begin
      acc[a_idx] <= acc_nxt;
      if (at_first) mode_q <= mode;
    end
  end

  // Output register: a new result may replace the old one only on its handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept && is_final && !early_last) begin
      out_valid <= 1'b1;
      out_data  <= pix_res;
      out_last  <= at_last_pos;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_err <= 1'b0;
    else if (clear)
      frame_err <= 1'b0;
    else if (accept && (in_last ^ at_last_pos))
      frame_err <= 1'b1;
  end

endmodule

// File: tb/tb_stream_pool2d.sv
// Directed bench for stream_pool2d on a 4x4 frame with 2x2 windows.
module tb_stream_pool2d;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] outq[$];

  stream_pool2d #(
    .RESOLUTION(8),
    .IMG_WIDTH (4),
    .IMG_HEIGHT(4),
    .POOL      (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output that will complete its handshake on the next rising edge.
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) outq.push_back({out_last, out_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [7:0] p, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = p;
    in_last  = l;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("send accepted", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_ramp(input logic m, input logic with_last);
    mode = m;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), with_last && (i == 15));
      if (i == 0) mode = ~m;
    end
  endtask

  task automatic send_const(input logic [7:0] v);
    for (int i = 0; i < 16; i++) send(v, i == 15);
  endtask

  task automatic expect4(input string tag, input int e0, input int e1, input int e2, input int e3);
    int ex[4];
    ex = '{e0, e1, e2, e3};
    repeat (3) @(negedge clk);
    check({tag, " count"}, outq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < outq.size()) begin
        check($sformatf("%s data[%0d]", tag, i), outq[i][7:0], ex[i]);
        check($sformatf("%s last[%0d]", tag, i), outq[i][8], (i == 3) ? 1 : 0);
      end
    end
    outq.delete();
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; mode = 1'b0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_last", out_last, 0);
    check("rst frame_err", frame_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send_const(8'd5);
    expect4("const5", 5, 5, 5, 5);
    check("const5 frame_err", frame_err, 0);

    send_ramp(1'b0, 1'b1);
    expect4("ramp avg", 3, 5, 11, 13);
    send_ramp(1'b1, 1'b1);
    expect4("ramp max", 5, 7, 13, 15);

    mode = 1'b0;
    send_const(8'd255);
    expect4("all255", 255, 255, 255, 255);

    for (int i = 0; i < 16; i++)
      send((i == 0 || i == 1 || i == 4) ? 8'd1 : 8'd0, i == 15);
    expect4("round", 1, 0, 0, 0);

    // Backpressure: stall the first result for five cycles.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(8'(i), i == 15);
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("bp first valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          #1;
          check("bp hold data", out_data, 3);
          check("bp in_ready low", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    expect4("bp", 3, 5, 11, 13);

    // Early in_last on pixel 6 truncates the frame.
    for (int i = 0; i < 7; i++) send(8'(i), i == 6);
    repeat (3) @(negedge clk);
    check("early frame_err", frame_err, 1);
    check("early count", outq.size(), 1);
    if (outq.size() > 0) check("early data", outq[0], 9'd3);
    outq.delete();
    send_ramp(1'b0, 1'b1);
    expect4("after early", 3, 5, 11, 13);
    check("err sticky", frame_err, 1);

    // clear blocks the presented pixel and drops the error.
    in_valid = 1'b1; in_data = 8'd99; in_last = 1'b1; clear = 1'b1;
    #1;
    check("clear in_ready", in_ready, 0);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("clear frame_err", frame_err, 0);
    send_ramp(1'b0, 1'b1);
    expect4("after clear", 3, 5, 11, 13);
    check("after clear err", frame_err, 0);

    // Missing in_last on the final pixel: still emitted, error flagged.
    send_ramp(1'b0, 1'b0);
    expect4("no last", 3, 5, 11, 13);
    check("no last frame_err", frame_err, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;

    // Reset mid-frame after six accepted pixels.
    mode = 1'b0;
    for (int i = 0; i < 6; i++) send(8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst out_data", out_data, 0);
    check("midrst out_last", out_last, 0);
    check("midrst frame_err", frame_err, 0);
    check("midrst no outputs", outq.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    outq.delete();
    @(negedge clk);
    send_const(8'd5);
    expect4("post rst", 5, 5, 5, 5);
    check("post rst err", frame_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_pool2d.md
Name: stream_pool2d

Overview:
- Streaming 2-D pooling engine for the digit-recognition pre-processing path.
- Accepts a raster-order pixel stream of one IMG_WIDTH x IMG_HEIGHT frame and emits one pooled pixel per POOL x POOL window, in raster order.
- Runtime mode selects rounded average or max.
- Successor to the fixed flat-bus average pooler: frame size, window size and resolution are parametrised, both sides use valid/ready, and frames are checked for alignment.

Parameters:
- RESOLUTION, 8, bits per pixel.
- IMG_WIDTH, 4, pixels per row; must be a multiple of POOL.
- IMG_HEIGHT, 4, rows per frame; must be a multiple of POOL.
- POOL, 2, window edge; must be a power of two, >=2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous frame abort.
- mode  in  1  0 = average, 1 = max; latched on the first pixel of each frame.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted when in_valid & in_ready.
- in_data  in  RESOLUTION  pixel value, unsigned.
- in_last  in  1  marks the final pixel of a frame.
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_data  out  RESOLUTION  pooled pixel.
- out_last  out  1  marks the final pooled pixel of a frame.
- frame_err  out  1  sticky alignment error.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_last=0, frame_err=0; col/row counters=0; accumulators=0; latched mode=0.
- Accumulator width: ACC_W = RESOLUTION + 2*log2(POOL). There are IMG_WIDTH/POOL accumulators, one per window column.
- in_ready is combinational: in_ready = ~out_valid | out_ready.
- On each accepted pixel at (col,row), the accumulator is a = col/POOL:
  - Window origin (col%POOL==0 and row%POOL==0): acc[a] <= pixel. This overwrites; no clear pass is needed.
  - Otherwise, average mode: acc[a] <= acc[a] + pixel.
  - Otherwise, max mode: acc[a] <= max(acc[a], pixel).
- Window completion (col%POOL==POOL-1 and row%POOL==POOL-1):
  - The result is combined from acc[a] and the current pixel.
  - Average: (sum + POOL*POOL/2) >> (2*log2(POOL)), i.e. round half up. The result never exceeds 2^RESOLUTION-1.
  - Max: the maximum of the window.
  - Result is registered into out_data with out_valid=1 on the next clock edge (latency 1 cycle).
  - out_last=1 iff this was the final window of the frame.
- Output hold: out_valid, out_data and out_last stay stable until the handshake completes.
  - If out_ready is high on the same edge a new result is produced, the register is replaced without a bubble.
- Counters: col increments per accepted pixel and wraps at IMG_WIDTH-1, incrementing row. row wraps at IMG_HEIGHT-1 to 0, and the next frame starts.
- Mode is latched when a pixel is accepted at (0,0). Changes to mode mid-frame have no effect.
- Alignment check:
  - in_last accepted at a position other than the final one sets frame_err and forces counters to 0. The window containing that pixel is not emitted.
  - The final position accepted without in_last sets frame_err. Its output is still emitted and counters wrap normally.
- clear (synchronous, highest priority after reset):
  - counters=0, out_valid=0, out_last=0, frame_err=0.
  - The pixel presented in the same cycle is not accepted (in_ready is forced low while clear=1).
- Reset mid-frame discards all partial sums; the next pixel is treated as (0,0).

Decomposition:
- Shared package pool_pkg holds:
  - MODE_AVG=0 and MODE_MAX=1.
  - A clog2 constant function.
  - The ACC_W derivation.
- One sub-module, pool_combine: purely combinational. Inputs are mode, accumulator and pixel, plus an is_origin/is_final flag. Outputs are the next accumulator value and the rounded or saturated output pixel.
- The top level holds the counters, accumulator array, mode latch, output register and error logic.

Test Plan:
- Defaults, mode=0, 16 pixels all 5, out_ready=1: exactly 4 outputs of 5, out_last only on the 4th, frame_err=0.
- Pixels 0..15 in raster order, mode=0 → outputs 3,5,11,13. Same frame with mode=1 → 5,7,13,15.
- All pixels 255, mode=0 → four outputs of 255 (no overflow). Window {1,1,1,0} → 1 (rounding).
- Backpressure: hold out_ready=0 for 5 cycles after the first output. out_data stays 3, in_ready stays 0, and after release all 4 outputs arrive in order with none lost.
- in_last asserted on pixel index 6: frame_err=1 and no output for that window. A following clean 0..15 frame yields 3,5,11,13. clear drops frame_err to 0.
- Assert rst_n low after 6 accepted pixels: all outputs read 0. The next full all-5 frame yields four outputs of 5.
